// File: rtl/vc_mem_port_serializer.sv
// vc_mem_port_serializer
//
// Bridges one wide memory request onto a narrow memory port. The wide request is split into
// ceil(B/W) narrow beats (B = wide byte count, W = narrow beat bytes), the in-order narrow
// responses are gathered, and one wide response is returned. Only one wide transaction is
// ever in flight.
//
// Message layouts (MSB first):
//   request  : {type[0], addr[p_addr_sz-1:0], len[log2(bytes)-1:0], data}
//   response : {type[0], len[log2(bytes)-1:0], data}
//   type 0 = read, 1 = write; len 0 means the full data width of that port.
//
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   widereq_val/rdy/msg             wide request in
//   wideresp_val/rdy/msg            wide response out
//   narrowreq_val/rdy/msg           narrow request out
//   narrowresp_val/rdy/msg          narrow response in (type/len fields ignored)
//
// Multi-beat requests must be aligned to W bytes. The narrow memory has to be reset together
// with this block, since stale narrow responses are not filtered.

module vc_mem_port_serializer #(
    parameter int unsigned p_addr_sz        = 32,
    parameter int unsigned p_wide_data_sz   = 128,
    parameter int unsigned p_narrow_data_sz = 32,
    localparam int unsigned c_wlen_sz  = $clog2(p_wide_data_sz / 8),
    localparam int unsigned c_nlen_sz  = $clog2(p_narrow_data_sz / 8),
    localparam int unsigned c_wreq_sz  = 1 + p_addr_sz + c_wlen_sz + p_wide_data_sz,
    localparam int unsigned c_wresp_sz = 1 + c_wlen_sz + p_wide_data_sz,
    localparam int unsigned c_nreq_sz  = 1 + p_addr_sz + c_nlen_sz + p_narrow_data_sz,
    localparam int unsigned c_nresp_sz = 1 + c_nlen_sz + p_narrow_data_sz
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  widereq_val,
    output logic                  widereq_rdy,
    input  logic [c_wreq_sz-1:0]  widereq_msg,

    output logic                  wideresp_val,
    input  logic                  wideresp_rdy,
    output logic [c_wresp_sz-1:0] wideresp_msg,

    output logic                  narrowreq_val,
    input  logic                  narrowreq_rdy,
    output logic [c_nreq_sz-1:0]  narrowreq_msg,

    input  logic                  narrowresp_val,
    output logic                  narrowresp_rdy,
    input  logic [c_nresp_sz-1:0] narrowresp_msg
);

    localparam int unsigned c_wbytes  = p_wide_data_sz / 8;
    localparam int unsigned c_nbytes  = p_narrow_data_sz / 8;
    localparam int unsigned c_nwords  = p_wide_data_sz / p_narrow_data_sz;
    localparam int unsigned c_idx_sz  = $clog2(c_nwords);
    localparam int unsigned c_cnt_sz  = c_idx_sz + 1;   // counts 0..N inclusive
    localparam int unsigned c_bcnt_sz = c_wlen_sz + 1;  // byte count 0..wide bytes inclusive

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                      state_q;
    logic                        type_q;
    logic [p_addr_sz-1:0]        base_q;
    logic [c_wlen_sz-1:0]        len_q;
    logic [c_bcnt_sz-1:0]        bytes_q;
    logic [c_cnt_sz-1:0]         beats_q;
    logic [c_cnt_sz-1:0]         issue_cnt_q;
    logic [c_cnt_sz-1:0]         resp_cnt_q;
    logic [p_wide_data_sz-1:0]   data_q;
    logic [p_wide_data_sz-1:0]   asm_q;

    // Wide request fields
    logic                        wreq_type;
    logic [p_addr_sz-1:0]        wreq_addr;
    logic [c_wlen_sz-1:0]        wreq_len;
    logic [p_wide_data_sz-1:0]   wreq_data;
    logic [c_bcnt_sz-1:0]        wreq_bytes;
    logic [c_bcnt_sz-1:0]        wreq_bytes_up;
    logic [c_cnt_sz-1:0]         wreq_beats;

    assign wreq_type = widereq_msg[c_wreq_sz-1];
    assign wreq_addr = widereq_msg[p_wide_data_sz + c_wlen_sz +: p_addr_sz];
    assign wreq_len  = widereq_msg[p_wide_data_sz +: c_wlen_sz];
    assign wreq_data = widereq_msg[p_wide_data_sz-1:0];

    assign wreq_bytes    = (wreq_len == '0) ? c_bcnt_sz'(c_wbytes) : {1'b0, wreq_len};
    // Round up to whole beats before dividing by the beat size
    assign wreq_bytes_up = wreq_bytes + c_bcnt_sz'(c_nbytes - 1);
    assign wreq_beats    = c_cnt_sz'(wreq_bytes_up >> c_nlen_sz);

    // Current beat being issued
    logic [c_idx_sz-1:0]         issue_idx;
    logic [c_idx_sz-1:0]         resp_idx;
    logic [c_bcnt_sz-1:0]        beat_off;
    logic [c_bcnt_sz-1:0]        beat_rem;
    logic [c_nlen_sz-1:0]        beat_len;
    logic [p_addr_sz-1:0]        beat_addr;
    logic [p_narrow_data_sz-1:0] beat_data;

    assign issue_idx = issue_cnt_q[c_idx_sz-1:0];
    assign resp_idx  = resp_cnt_q[c_idx_sz-1:0];
    assign beat_off  = c_bcnt_sz'(issue_cnt_q) << c_nlen_sz;
    assign beat_rem  = bytes_q - beat_off;
    // A full beat is encoded as len 0 on the narrow side
    assign beat_len  = (beat_rem >= c_bcnt_sz'(c_nbytes)) ? '0 : beat_rem[c_nlen_sz-1:0];
    assign beat_addr = base_q + (p_addr_sz'(issue_cnt_q) << c_nlen_sz);
    assign beat_data = type_q ? data_q[issue_idx * p_narrow_data_sz +: p_narrow_data_sz] : '0;

    logic [p_narrow_data_sz-1:0] nresp_data;
    logic                        unused_nresp_hdr;

    assign nresp_data       = narrowresp_msg[p_narrow_data_sz-1:0];
    assign unused_nresp_hdr = ^narrowresp_msg[c_nresp_sz-1:p_narrow_data_sz];

    // Handshake outputs depend only on registered state; everything is forced low in reset
    assign widereq_rdy    = reset && (state_q == StIdle);
    assign narrowreq_val  = reset && (state_q == StBusy) && (issue_cnt_q < beats_q);
    assign narrowresp_rdy = reset && (state_q == StBusy) && (resp_cnt_q < issue_cnt_q);
    assign wideresp_val   = reset && (state_q == StResp);

    assign narrowreq_msg  = reset ? {type_q, beat_addr, beat_len, beat_data} : '0;
    assign wideresp_msg   = reset ? {type_q, len_q, asm_q} : '0;

    logic narrowreq_fire;
    logic narrowresp_fire;

    assign narrowreq_fire  = narrowreq_val && narrowreq_rdy;
    assign narrowresp_fire = narrowresp_rdy && narrowresp_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            type_q      <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            bytes_q     <= '0;
            beats_q     <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            data_q      <= '0;
            asm_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (widereq_val) begin
                        type_q      <= wreq_type;
                        base_q      <= wreq_addr;
                        len_q       <= wreq_len;
                        bytes_q     <= wreq_bytes;
                        beats_q     <= wreq_beats;
                        data_q      <= wreq_data;
                        asm_q       <= '0;
                        issue_cnt_q <= '0;
                        resp_cnt_q  <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (narrowreq_fire) begin
                        issue_cnt_q <= issue_cnt_q + c_cnt_sz'(1);
                    end
                    if (narrowresp_fire) begin
                        if (!type_q) begin
                            asm_q[resp_idx * p_narrow_data_sz +: p_narrow_data_sz] <= nresp_data;
                        end
                        resp_cnt_q <= resp_cnt_q + c_cnt_sz'(1);
                        if (resp_cnt_q == beats_q - c_cnt_sz'(1)) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (wideresp_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_mem_port_serializer.sv
module tb_vc_mem_port_serializer;

    localparam int WREQ  = 165;
    localparam int WRESP = 133;
    localparam int NREQ  = 67;
    localparam int NRESP = 35;

    logic             clk = 1'b0;
    logic             reset;
    logic             widereq_val;
    logic             widereq_rdy;
    logic [WREQ-1:0]  widereq_msg;
    logic             wideresp_val;
    logic             wideresp_rdy;
    logic [WRESP-1:0] wideresp_msg;
    logic             narrowreq_val;
    logic             narrowreq_rdy = 1'b1;
    logic [NREQ-1:0]  narrowreq_msg;
    logic             narrowresp_val = 1'b0;
    logic             narrowresp_rdy;
    logic [NRESP-1:0] narrowresp_msg = '0;

    vc_mem_port_serializer #(
        .p_addr_sz        (32),
        .p_wide_data_sz   (128),
        .p_narrow_data_sz (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .widereq_val    (widereq_val),
        .widereq_rdy    (widereq_rdy),
        .widereq_msg    (widereq_msg),
        .wideresp_val   (wideresp_val),
        .wideresp_rdy   (wideresp_rdy),
        .wideresp_msg   (wideresp_msg),
        .narrowreq_val  (narrowreq_val),
        .narrowreq_rdy  (narrowreq_rdy),
        .narrowreq_msg  (narrowreq_msg),
        .narrowresp_val (narrowresp_val),
        .narrowresp_rdy (narrowresp_rdy),
        .narrowresp_msg (narrowresp_msg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int accept_cyc;
    int resp_cyc;

    // Narrow memory model: logs each request, answers in order one cycle later
    logic [NREQ-1:0] req_log[$];
    logic [31:0]     rd_data[$];
    logic [31:0]     pend[$];
    logic [31:0]     dummy;
    bit              nrdy_toggle = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            pend.delete();
        end else begin
            if (narrowresp_val && narrowresp_rdy) dummy = pend.pop_front();
            if (narrowreq_val && narrowreq_rdy) begin
                req_log.push_back(narrowreq_msg);
                if (rd_data.size() > 0) pend.push_back(rd_data.pop_front());
                else pend.push_back(32'h0);
            end
        end
    end

    always @(negedge clk) begin
        narrowresp_val = (pend.size() > 0);
        narrowresp_msg = {3'b101, (pend.size() > 0) ? pend[0] : 32'h0};
        narrowreq_rdy  = nrdy_toggle ? ~narrowreq_rdy : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic send_wide(input logic t, input logic [31:0] a, input logic [3:0] l,
                             input logic [127:0] d);
        int n = 0;
        widereq_msg = {t, a, l, d};
        widereq_val = 1'b1;
        while (!widereq_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        accept_cyc = cyc;
        check("accept_in_time", widereq_rdy, 1'b1);
        @(negedge clk);
        widereq_val = 1'b0;
    endtask

    task automatic wait_resp(output logic [WRESP-1:0] m);
        int n = 0;
        while (!wideresp_val && n < 200) begin
            @(negedge clk);
            n++;
        end
        resp_cyc = cyc;
        m = wideresp_msg;
        check("resp_in_time", wideresp_val, 1'b1);
    endtask

    task automatic check_beat(input string tag, input int i, input logic [NREQ-1:0] exp);
        logic [NREQ-1:0] got;
        got = (i < req_log.size()) ? req_log[i] : '0;
        check(tag, got, exp);
    endtask

    logic [WRESP-1:0] msg;
    logic [WRESP-1:0] held;
    logic [31:0]      a_i;

    initial begin
        reset = 1'b0;
        widereq_val = 1'b0;
        widereq_msg = '0;
        wideresp_rdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_widereq_rdy", widereq_rdy, 1'b0);
        check("rst_narrowreq_val", narrowreq_val, 1'b0);
        check("rst_wideresp_val", wideresp_val, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_widereq_rdy", widereq_rdy, 1'b1);
        check("idle_narrowreq_val", narrowreq_val, 1'b0);
        check("idle_narrowresp_rdy", narrowresp_rdy, 1'b0);
        check("idle_wideresp_val", wideresp_val, 1'b0);

        // 1: full-width read, four beats
        req_log.delete();
        rd_data.push_back(32'h11111111);
        rd_data.push_back(32'h22222222);
        rd_data.push_back(32'h33333333);
        rd_data.push_back(32'h44444444);
        send_wide(1'b0, 32'h1000, 4'h0, 128'h0);
        wait_resp(msg);
        check("t1_resp", msg, {1'b0, 4'h0, 128'h44444444_33333333_22222222_11111111});
        check("t1_nbeats", req_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a_i = 32'h1000 + 32'(4 * i);
            check_beat("t1_beat", i, {1'b0, a_i, 2'b00, 32'h0});
        end

        // 2: 6-byte write, two beats, second one partial
        @(negedge clk);
        req_log.delete();
        rd_data.push_back(32'hFFFFFFFF);
        rd_data.push_back(32'hFFFFFFFF);
        send_wide(1'b1, 32'h2000, 4'h6, 128'hFFFF0000_12345678_0000BBBB_AAAAAAAA);
        wait_resp(msg);
        check("t2_resp", msg, {1'b1, 4'h6, 128'h0});
        check("t2_nbeats", req_log.size(), 2);
        check_beat("t2_beat0", 0, {1'b1, 32'h2000, 2'b00, 32'hAAAAAAAA});
        check_beat("t2_beat1", 1, {1'b1, 32'h2004, 2'd2, 32'h0000BBBB});

        // 3: single-beat reads, full beat and partial misaligned
        @(negedge clk);
        req_log.delete();
        rd_data.push_back(32'hDEADBEEF);
        send_wide(1'b0, 32'h3004, 4'h4, 128'h0);
        wait_resp(msg);
        check("t3a_resp", msg, {1'b0, 4'h4, 128'hDEADBEEF});
        check("t3a_nbeats", req_log.size(), 1);
        check_beat("t3a_beat", 0, {1'b0, 32'h3004, 2'b00, 32'h0});
        @(negedge clk);
        req_log.delete();
        rd_data.push_back(32'h0000CAFE);
        send_wide(1'b0, 32'h3001, 4'h2, 128'h0);
        wait_resp(msg);
        check("t3b_resp", msg, {1'b0, 4'h2, 128'h0000CAFE});
        check("t3b_nbeats", req_log.size(), 1);
        check_beat("t3b_beat", 0, {1'b0, 32'h3001, 2'd2, 32'h0});

        // 4: narrow ready toggling, wide response stalled five cycles
        @(negedge clk);
        req_log.delete();
        nrdy_toggle = 1'b1;
        wideresp_rdy = 1'b0;
        rd_data.push_back(32'hA0A0A0A0);
        rd_data.push_back(32'hB1B1B1B1);
        rd_data.push_back(32'hC2C2C2C2);
        rd_data.push_back(32'hD3D3D3D3);
        send_wide(1'b0, 32'h4000, 4'h0, 128'h0);
        wait_resp(msg);
        check("t4_resp", msg, {1'b0, 4'h0, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0});
        held = msg;
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_msg", wideresp_msg, held);
            check("t4_stall_val", wideresp_val, 1'b1);
            check("t4_stall_wreq_rdy", widereq_rdy, 1'b0);
            @(negedge clk);
        end
        wideresp_rdy = 1'b1;
        nrdy_toggle = 1'b0;
        @(negedge clk);
        check("t4_after_val", wideresp_val, 1'b0);
        check("t4_after_wreq_rdy", widereq_rdy, 1'b1);
        check("t4_nbeats", req_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a_i = 32'h4000 + 32'(4 * i);
            check_beat("t4_beat", i, {1'b0, a_i, 2'b00, 32'h0});
        end

        // 5: pipelined beats, latency, back-to-back wide requests
        @(negedge clk);
        req_log.delete();
        rd_data.push_back(32'h01020304);
        rd_data.push_back(32'h05060708);
        rd_data.push_back(32'h090A0B0C);
        rd_data.push_back(32'h0D0E0F10);
        send_wide(1'b0, 32'h5000, 4'h0, 128'h0);
        wait_resp(msg);
        check("t5_latency", resp_cyc - accept_cyc, 6);
        check("t5_resp", msg, {1'b0, 4'h0, 128'h0D0E0F10_090A0B0C_05060708_01020304});
        rd_data.push_back(32'h99990000);
        rd_data.push_back(32'h99990001);
        rd_data.push_back(32'h99990002);
        rd_data.push_back(32'h99990003);
        send_wide(1'b0, 32'h5100, 4'h0, 128'h0);
        wait_resp(msg);
        check("t5b_latency", resp_cyc - accept_cyc, 6);
        check("t5b_resp", msg, {1'b0, 4'h0, 128'h99990003_99990002_99990001_99990000});
        check("t5_nbeats", req_log.size(), 8);
        check_beat("t5b_beat3", 7, {1'b0, 32'h510C, 2'b00, 32'h0});

        // 6: reset in the middle of a four-beat read
        @(negedge clk);
        req_log.delete();
        rd_data.push_back(32'hEEEE0000);
        rd_data.push_back(32'hEEEE0001);
        rd_data.push_back(32'hEEEE0002);
        rd_data.push_back(32'hEEEE0003);
        send_wide(1'b0, 32'h6000, 4'h0, 128'h0);
        for (int n = 0; n < 50 && req_log.size() < 2; n++) @(negedge clk);
        check("t6_two_issued", req_log.size(), 2);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_wreq_rdy", widereq_rdy, 1'b0);
        check("t6_rst_nreq_val", narrowreq_val, 1'b0);
        check("t6_rst_nresp_rdy", narrowresp_rdy, 1'b0);
        check("t6_rst_wresp_val", wideresp_val, 1'b0);
        reset = 1'b1;
        rd_data.delete();
        @(negedge clk);
        check("t6_rel_wreq_rdy", widereq_rdy, 1'b1);
        check("t6_no_extra_beats", req_log.size(), 2);
        req_log.delete();
        rd_data.push_back(32'h5A5A5A5A);
        send_wide(1'b0, 32'h6100, 4'h4, 128'h0);
        wait_resp(msg);
        check("t6_resp", msg, {1'b0, 4'h4, 128'h5A5A5A5A});
        check_beat("t6_beat", 0, {1'b0, 32'h6100, 2'b00, 32'h0});

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
